// File: rtl/pipeline_trace_tracker_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module : trace_pkg                                                         |
// | Shared types and helpers for the pipeline instruction-lifecycle tracker.   |
// | Rev    : 1.0                                                               |
// +----------------------------------------------------------------------------+
package trace_pkg;

    localparam int unsigned C_DEF_ID_W    = 8;
    localparam int unsigned C_DEF_PC_W    = 16;
    localparam int unsigned C_DEF_CYC_W   = 16;
    localparam int unsigned C_DEF_STALL_W = 4;
    localparam int unsigned MAX_STAGES    = 8;
    localparam int unsigned MAX_STALL_W   = 16;

    // Reference record layout at the default widths; slots hold the same fields.
    typedef struct packed {
        logic                     valid;
        logic [C_DEF_ID_W-1:0]    id;
        logic [C_DEF_PC_W-1:0]    pc;
        logic [C_DEF_CYC_W-1:0]   stamp;
        logic [C_DEF_STALL_W-1:0] stalls;
    } trace_entry_t;

    function automatic logic [MAX_STALL_W-1:0] sat_inc(
        input logic [MAX_STALL_W-1:0] value,
        input logic [MAX_STALL_W-1:0] max_value
    );
        return (value >= max_value) ? max_value : value + MAX_STALL_W'(1);
    endfunction

    function automatic logic [3:0] popcount(input logic [MAX_STAGES-1:0] bits);
        logic [3:0] cnt;
        cnt = '0;
        for (int i = 0; i < int'(MAX_STAGES); i++) begin
            cnt = cnt + {3'b000, bits[i]};
        end
        return cnt;
    endfunction

endpackage
`default_nettype wire

// File: rtl/pipeline_trace_tracker_slot.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module : trace_stage_slot                                                  |
// | One pipeline stage record with clear / hold(+stall count) / load control.  |
// | Rev    : 1.0                                                               |
// +----------------------------------------------------------------------------+
module trace_stage_slot
    import trace_pkg::*;
#(
    parameter int ID_W    = 8,
    parameter int PC_W    = 16,
    parameter int CYC_W   = 16,
    parameter int STALL_W = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               i_clear,
    input  logic               i_hold,
    input  logic               i_valid,
    input  logic [ID_W-1:0]    i_id,
    input  logic [PC_W-1:0]    i_pc,
    input  logic [CYC_W-1:0]   i_stamp,
    input  logic [STALL_W-1:0] i_stalls,
    output logic               o_valid,
    output logic [ID_W-1:0]    o_id,
    output logic [PC_W-1:0]    o_pc,
    output logic [CYC_W-1:0]   o_stamp,
    output logic [STALL_W-1:0] o_stalls
);

    logic               valid_q, valid_d;
    logic [ID_W-1:0]    id_q, id_d;
    logic [PC_W-1:0]    pc_q, pc_d;
    logic [CYC_W-1:0]   stamp_q, stamp_d;
    logic [STALL_W-1:0] stalls_q, stalls_d;
    logic [MAX_STALL_W-1:0] w_stalls_ext;
    logic [MAX_STALL_W-1:0] w_stalls_max;

    always_comb begin
        valid_d      = valid_q;
        id_d         = id_q;
        pc_d         = pc_q;
        stamp_d      = stamp_q;
        stalls_d     = stalls_q;
        w_stalls_ext = MAX_STALL_W'(stalls_q);
        w_stalls_max = MAX_STALL_W'({STALL_W{1'b1}});
        if (i_clear) begin
            valid_d  = 1'b0;
            id_d     = '0;
            pc_d     = '0;
            stamp_d  = '0;
            stalls_d = '0;
        end else if (i_hold) begin
            if (valid_q) begin
                stalls_d = STALL_W'(sat_inc(w_stalls_ext, w_stalls_max));
            end
        end else begin
            valid_d  = i_valid;
            id_d     = i_id;
            pc_d     = i_pc;
            stamp_d  = i_stamp;
            stalls_d = i_stalls;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q  <= 1'b0;
            id_q     <= '0;
            pc_q     <= '0;
            stamp_q  <= '0;
            stalls_q <= '0;
        end else begin
            valid_q  <= valid_d;
            id_q     <= id_d;
            pc_q     <= pc_d;
            stamp_q  <= stamp_d;
            stalls_q <= stalls_d;
        end
    end

    assign o_valid  = valid_q;
    assign o_id     = id_q;
    assign o_pc     = pc_q;
    assign o_stamp  = stamp_q;
    assign o_stalls = stalls_q;

endmodule
`default_nettype wire

// File: rtl/pipeline_trace_tracker.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module : pipeline_trace_tracker                                            |
// | Tags fetches, shadows stage occupancy under stall/flush, emits retires.    |
// | Rev    : 1.0                                                               |
// +----------------------------------------------------------------------------+
module pipeline_trace_tracker
    import trace_pkg::*;
#(
    parameter int NUM_STAGES   = 5,
    parameter int STALL_STAGES = 2,
    parameter int FLUSH_STAGES = 2,
    parameter int ID_W         = 8,
    parameter int PC_W         = 16,
    parameter int CYC_W        = 16,
    parameter int STALL_W      = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               fetch_valid,
    input  logic [PC_W-1:0]    fetch_pc,
    input  logic               stall,
    input  logic               flush,
    output logic [CYC_W-1:0]   cycle_cnt,
    output logic               ret_valid,
    output logic [ID_W-1:0]    ret_id,
    output logic [PC_W-1:0]    ret_pc,
    output logic [STALL_W-1:0] ret_stalls,
    output logic [CYC_W-1:0]   ret_latency,
    output logic [31:0]        retire_count,
    output logic [31:0]        flush_count,
    output logic               err_order
);

    localparam int LAST = NUM_STAGES - 1;
    localparam logic [NUM_STAGES-1:0] C_FLUSH_MASK = NUM_STAGES'((1 << FLUSH_STAGES) - 1);

    logic [NUM_STAGES-1:0] w_valid;
    logic [NUM_STAGES-1:0] w_src_valid;
    logic [ID_W-1:0]       w_id       [NUM_STAGES];
    logic [ID_W-1:0]       w_src_id   [NUM_STAGES];
    logic [PC_W-1:0]       w_pc       [NUM_STAGES];
    logic [PC_W-1:0]       w_src_pc   [NUM_STAGES];
    logic [CYC_W-1:0]      w_stamp    [NUM_STAGES];
    logic [CYC_W-1:0]      w_src_stamp[NUM_STAGES];
    logic [STALL_W-1:0]    w_stalls   [NUM_STAGES];
    logic [STALL_W-1:0]    w_src_stalls[NUM_STAGES];

    logic              w_accept;
    logic [CYC_W-1:0]  cycle_cnt_q, cycle_cnt_d;
    logic [ID_W-1:0]   next_id_q, next_id_d;
    logic [31:0]       retire_count_q, retire_count_d;
    logic [31:0]       flush_count_q, flush_count_d;
    logic [ID_W-1:0]   last_ret_id_q, last_ret_id_d;
    logic              seen_q, seen_d;
    logic              err_order_q, err_order_d;
    logic [ID_W-1:0]   w_dist;

    assign w_accept = fetch_valid & ~stall & ~flush;

    genvar k;
    generate
        for (k = 0; k < NUM_STAGES; k++) begin : g_slot
            localparam logic IN_FLUSH = (k < FLUSH_STAGES);
            localparam logic IN_STALL = (k < STALL_STAGES);
            logic w_clear;
            logic w_hold;

            assign w_clear = flush & IN_FLUSH;
            assign w_hold  = ~flush & stall & IN_STALL;

            if (k == 0) begin : g_head
                assign w_src_valid[k]  = w_accept;
                assign w_src_id[k]     = w_accept ? next_id_q   : '0;
                assign w_src_pc[k]     = w_accept ? fetch_pc    : '0;
                assign w_src_stamp[k]  = w_accept ? cycle_cnt_q : '0;
                assign w_src_stalls[k] = '0;
            end else begin : g_body
                localparam logic BUBBLE_FLUSH = (k == FLUSH_STAGES);
                localparam logic BUBBLE_STALL = (k == STALL_STAGES);
                logic w_bubble;
                // The slot just above the frozen/cleared front takes a bubble.
                assign w_bubble        = (flush & BUBBLE_FLUSH) | (~flush & stall & BUBBLE_STALL);
                assign w_src_valid[k]  = w_bubble ? 1'b0 : w_valid[k-1];
                assign w_src_id[k]     = w_bubble ? '0   : w_id[k-1];
                assign w_src_pc[k]     = w_bubble ? '0   : w_pc[k-1];
                assign w_src_stamp[k]  = w_bubble ? '0   : w_stamp[k-1];
                assign w_src_stalls[k] = w_bubble ? '0   : w_stalls[k-1];
            end

            trace_stage_slot #(
                .ID_W    (ID_W),
                .PC_W    (PC_W),
                .CYC_W   (CYC_W),
                .STALL_W (STALL_W)
            ) u_slot (
                .clk      (clk),
                .rst      (rst),
                .i_clear  (w_clear),
                .i_hold   (w_hold),
                .i_valid  (w_src_valid[k]),
                .i_id     (w_src_id[k]),
                .i_pc     (w_src_pc[k]),
                .i_stamp  (w_src_stamp[k]),
                .i_stalls (w_src_stalls[k]),
                .o_valid  (w_valid[k]),
                .o_id     (w_id[k]),
                .o_pc     (w_pc[k]),
                .o_stamp  (w_stamp[k]),
                .o_stalls (w_stalls[k])
            );
        end
    endgenerate

    always_comb begin
        cycle_cnt_d    = cycle_cnt_q + CYC_W'(1);
        next_id_d      = next_id_q;
        retire_count_d = retire_count_q;
        flush_count_d  = flush_count_q;
        last_ret_id_d  = last_ret_id_q;
        seen_d         = seen_q;
        err_order_d    = err_order_q;
        w_dist         = w_id[LAST] - last_ret_id_q;
        if (w_accept) begin
            next_id_d = next_id_q + ID_W'(1);
        end
        if (flush) begin
            flush_count_d = flush_count_q
                          + 32'(popcount(MAX_STAGES'(w_valid & C_FLUSH_MASK)));
        end
        if (w_valid[LAST]) begin
            retire_count_d = retire_count_q + 32'd1;
            last_ret_id_d  = w_id[LAST];
            seen_d         = 1'b1;
            // Repeats or backward steps are errors; forward gaps come from flushes.
            if (seen_q && ((w_dist == '0) || w_dist[ID_W-1])) begin
                err_order_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cycle_cnt_q    <= '0;
            next_id_q      <= '0;
            retire_count_q <= '0;
            flush_count_q  <= '0;
            last_ret_id_q  <= '0;
            seen_q         <= 1'b0;
            err_order_q    <= 1'b0;
        end else begin
            cycle_cnt_q    <= cycle_cnt_d;
            next_id_q      <= next_id_d;
            retire_count_q <= retire_count_d;
            flush_count_q  <= flush_count_d;
            last_ret_id_q  <= last_ret_id_d;
            seen_q         <= seen_d;
            err_order_q    <= err_order_d;
        end
    end

    assign cycle_cnt    = cycle_cnt_q;
    assign ret_valid    = w_valid[LAST];
    assign ret_id       = w_id[LAST];
    assign ret_pc       = w_pc[LAST];
    assign ret_stalls   = w_stalls[LAST];
    assign ret_latency  = cycle_cnt_q - w_stamp[LAST];
    assign retire_count = retire_count_q;
    assign flush_count  = flush_count_q;
    assign err_order    = err_order_q;

endmodule
`default_nettype wire

// File: tb/tb_pipeline_trace_tracker.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module : tb_pipeline_trace_tracker                                         |
// | Directed + random bench against a per-instruction position model.        |
// | Rev    : 1.0                                                               |
// +----------------------------------------------------------------------------+
module tb_pipeline_trace_tracker;

    localparam int N = 5;
    localparam int S = 2;
    localparam int F = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        fetch_valid = 1'b0;
    logic [15:0] fetch_pc = '0;
    logic        stall = 1'b0;
    logic        flush = 1'b0;
    logic [15:0] cycle_cnt;
    logic        ret_valid;
    logic [7:0]  ret_id;
    logic [15:0] ret_pc;
    logic [3:0]  ret_stalls;
    logic [15:0] ret_latency;
    logic [31:0] retire_count;
    logic [31:0] flush_count;
    logic        err_order;

    pipeline_trace_tracker dut (
        .clk          (clk),
        .rst          (rst),
        .fetch_valid  (fetch_valid),
        .fetch_pc     (fetch_pc),
        .stall        (stall),
        .flush        (flush),
        .cycle_cnt    (cycle_cnt),
        .ret_valid    (ret_valid),
        .ret_id       (ret_id),
        .ret_pc       (ret_pc),
        .ret_stalls   (ret_stalls),
        .ret_latency  (ret_latency),
        .retire_count (retire_count),
        .flush_count  (flush_count),
        .err_order    (err_order)
    );

    always #5 clk = ~clk;

    // Each in-flight instruction tracked by its current stage position.
    typedef struct {
        int pos;
        int id;
        int pc;
        int stamp;
        int stalls;
    } inst_t;

    inst_t       m_q[$];
    int          m_cyc, m_nid, m_last;
    bit          m_seen, m_err;
    logic [31:0] m_rc, m_fc;
    int          n_total = 0;
    int          n_pass  = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic model_edge(input bit fv, input int pc, input bit st, input bit fl, input bit r);
        inst_t nq[$];
        inst_t e;
        int    d;
        if (r) begin
            m_q.delete();
            m_cyc = 0; m_nid = 0; m_last = 0; m_seen = 0; m_err = 0; m_rc = 0; m_fc = 0;
            return;
        end
        foreach (m_q[i]) begin
            if (m_q[i].pos == N - 1) begin
                m_rc = m_rc + 1;
                if (m_seen) begin
                    d = (m_q[i].id - m_last) & 255;
                    if (d == 0 || d >= 128) m_err = 1;
                end
                m_last = m_q[i].id;
                m_seen = 1;
            end
        end
        foreach (m_q[i]) begin
            e = m_q[i];
            if (fl && e.pos < F) begin
                m_fc = m_fc + 1;
            end else begin
                if (!fl && st && e.pos < S) e.stalls = (e.stalls < 15) ? e.stalls + 1 : 15;
                else e.pos++;
                if (e.pos < N) nq.push_back(e);
            end
        end
        if (fv && !st && !fl) begin
            nq.push_back('{0, m_nid, pc, m_cyc, 0});
            m_nid = (m_nid + 1) & 255;
        end
        m_q = nq;
        m_cyc = (m_cyc + 1) & 16'hffff;
    endtask

    task automatic check_outputs();
        bit    exp_v = 0;
        inst_t r;
        foreach (m_q[i]) if (m_q[i].pos == N - 1) begin exp_v = 1; r = m_q[i]; end
        chk("cycle_cnt", 32'(cycle_cnt), 32'(m_cyc));
        chk("ret_valid", 32'(ret_valid), 32'(exp_v));
        if (exp_v) begin
            chk("ret_id", 32'(ret_id), 32'(r.id));
            chk("ret_pc", 32'(ret_pc), 32'(r.pc));
            chk("ret_stalls", 32'(ret_stalls), 32'(r.stalls));
            chk("ret_latency", 32'(ret_latency), 32'((m_cyc - r.stamp) & 16'hffff));
        end
        chk("retire_count", retire_count, m_rc);
        chk("flush_count", flush_count, m_fc);
        chk("err_order", 32'(err_order), 32'(m_err));
    endtask

    task automatic step(input bit fv, input int pc, input bit st, input bit fl, input bit r, input bit en);
        fetch_valid = fv;
        fetch_pc    = 16'(pc);
        stall       = st;
        flush       = fl;
        rst         = r;
        @(posedge clk);
        model_edge(fv, pc & 16'hffff, st, fl, r);
        #1;
        if (en) check_outputs();
    endtask

    initial begin
        step(0, 0, 0, 0, 1, 1);
        step(0, 0, 0, 0, 1, 1);

        // Straight-line fetch of four instructions
        step(0, 0, 0, 0, 1, 1);
        for (int i = 0; i < 4; i++) step(1, 2 * i, 0, 0, 0, 1);
        for (int i = 0; i < 5; i++) step(0, 0, 0, 0, 0, 1);
        chk("plan1_retire_count", retire_count, 32'd4);

        // Stall while the entry sits in stage 1
        step(0, 0, 0, 0, 1, 1);
        step(1, 16'h100, 0, 0, 0, 1);
        step(0, 0, 0, 0, 0, 1);
        step(0, 0, 1, 0, 0, 1);
        step(0, 0, 1, 0, 0, 1);
        for (int i = 0; i < 6; i++) step(0, 0, 0, 0, 0, 1);

        // Flush squashing the two youngest entries
        step(0, 0, 0, 0, 1, 1);
        for (int i = 0; i < 5; i++) step(1, 16'h200 + i, 0, (i == 3), 0, 1);
        for (int i = 0; i < 6; i++) step(0, 0, 0, 0, 0, 1);
        chk("plan3_flush_count", flush_count, 32'd2);

        // Stall and flush together
        step(0, 0, 0, 0, 1, 1);
        step(1, 16'h300, 0, 0, 0, 1);
        step(1, 16'h302, 0, 0, 0, 1);
        step(1, 16'h304, 1, 1, 0, 1);
        chk("plan4_flush_count", flush_count, 32'd2);
        for (int i = 0; i < 6; i++) step(0, 0, 0, 0, 0, 1);

        // Long stall saturating the stall counter
        step(0, 0, 0, 0, 1, 1);
        step(1, 16'h400, 0, 0, 0, 1);
        for (int i = 0; i < 20; i++) step(0, 0, 1, 0, 0, 1);
        for (int i = 0; i < 4; i++) step(0, 0, 0, 0, 0, 1);
        chk("plan5_ret_valid", 32'(ret_valid), 32'd1);
        chk("plan5_ret_stalls", 32'(ret_stalls), 32'd15);
        chk("plan5_ret_latency", 32'(ret_latency), 32'd25);
        step(0, 0, 0, 0, 0, 1);

        // ID wrap then reset mid-stream
        step(0, 0, 0, 0, 1, 1);
        for (int i = 0; i < 300; i++) step(1, $urandom, 0, 0, 0, 1);
        step(1, $urandom, 0, 0, 1, 1);
        chk("plan6_ret_valid_after_rst", 32'(ret_valid), 32'd0);
        chk("plan6_retire_count_after_rst", retire_count, 32'd0);
        for (int i = 0; i < 8; i++) step(1, $urandom, 0, 0, 0, 1);

        // Random traffic
        for (int i = 0; i < 1500; i++) begin
            step($urandom_range(0, 9) < 7, $urandom, $urandom_range(0, 9) < 2,
                 $urandom_range(0, 99) < 8, $urandom_range(0, 299) == 0, 1);
        end

        // Cycle counter wrap with traffic straddling it
        step(0, 0, 0, 0, 1, 1);
        for (int i = 0; i < 65528; i++) step(0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 40; i++) begin
            step($urandom_range(0, 9) < 8, $urandom, $urandom_range(0, 9) < 2, 0, 0, 1);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
